// File: rtl/spw_ulight_nofifo_timec_rx_capture.sv
// Avalon-MM capture of received SpaceWire time-codes: data, sticky NEW/OVERRUN/SEQERR,
// tick counter and maskable level irq. Define SPW_TIMEC_RX_SEQCHK_EN to enable the sequence check.
module spw_ulight_nofifo_timec_rx_capture #(
    parameter int CNT_WIDTH = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        tick_in,
    input  logic [7:0]  time_in,
    output logic        irq
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic                 wr;
    logic [2:0]           clr;
    logic                 wr_mask;
    logic                 wr_cnt;
    logic [7:0]           data_q;
    logic                 new_q;
    logic                 ovr_q;
    logic                 seq_q;
    logic [2:0]           mask_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [2:0]           status;
    logic [31:0]          cnt_ext;
    logic                 unused_bits;

    assign wr      = chipselect & ~write_n;
    assign clr     = (wr && address == 2'd1) ? writedata[2:0] : 3'b000;
    assign wr_mask = wr && address == 2'd2;
    assign wr_cnt  = wr && address == 2'd3;

    // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_q <= '0;
            new_q  <= 1'b0;
            ovr_q  <= 1'b0;
            mask_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (tick_in) data_q <= time_in;
            // A set in the same cycle as its W1C wins; OVERRUN looks at NEW before the clear.
            new_q <= tick_in | (new_q & ~clr[0]);
            ovr_q <= (tick_in & new_q) | (ovr_q & ~clr[1]);
`ifdef SPW_TIMEC_RX_SEQCHK_EN
            if (wr_mask) mask_q <= writedata[2:0];
`else
            if (wr_mask) mask_q <= {1'b0, writedata[1:0]};
`endif
            if (tick_in) cnt_q <= wr_cnt ? CNT_ONE : cnt_q + CNT_ONE;
            else if (wr_cnt) cnt_q <= '0;
        end
    end

`ifdef SPW_TIMEC_RX_SEQCHK_EN
    logic [5:0] ref_q;
    logic       ref_valid_q;
    logic       seq_hit;

    // Only the 6-bit time value is compared; the sum wraps at 64 in the 6-bit context.
    assign seq_hit = tick_in && ref_valid_q && (time_in[5:0] != ref_q + 6'd1);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            seq_q       <= 1'b0;
            ref_q       <= '0;
            ref_valid_q <= 1'b0;
        end else begin
            seq_q <= seq_hit | (seq_q & ~clr[2]);
            if (tick_in) begin
                ref_q       <= time_in[5:0];
                ref_valid_q <= 1'b1;
            end
        end
    end
`else
    assign seq_q = 1'b0;
`endif

    assign status = {seq_q, ovr_q, new_q};
    assign irq    = |(status & mask_q);

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        cnt_ext                  = '0;
        cnt_ext[CNT_WIDTH-1:0]   = cnt_q;
        readdata                 = '0;
        case (address)
            2'd0:    readdata[7:0] = data_q;
            2'd1:    readdata[2:0] = status;
            2'd2:    readdata[2:0] = mask_q;
            default: readdata      = cnt_ext;
        endcase
    end

    assign unused_bits = ^writedata[31:3];

endmodule

// File: tb/tb_spw_ulight_nofifo_timec_rx_capture.sv
// Self-checking bench: directed vector table, hand-written corner sequences and
// randomized traffic compared against a behavioural model of the register map.
module tb_spw_ulight_nofifo_timec_rx_capture;

    localparam int CW = 4;
`ifdef SPW_TIMEC_RX_SEQCHK_EN
    localparam bit SEQ_EN = 1'b1;
`else
    localparam bit SEQ_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [1:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        tick_in = 1'b0;
    logic [7:0]  time_in = '0;
    logic        irq;

    spw_ulight_nofifo_timec_rx_capture #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .tick_in(tick_in), .time_in(time_in), .irq(irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model state; m_prev = -1 means no tick seen since reset.
    logic [7:0] m_data;
    bit         m_new, m_ovr, m_seq;
    logic [2:0] m_mask;
    int         m_cnt;
    int         m_prev;

    typedef struct {
        bit          rst;
        bit          tick;
        logic [7:0]  t;
        bit          wr;
        logic [1:0]  a;
        logic [31:0] wd;
        logic [7:0]  e_data;
        logic [2:0]  e_st;
        logic [31:0] e_cnt;
        bit          e_irq;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [2:0] m_status();
        return {m_seq, m_ovr, m_new};
    endfunction

    task automatic model_reset();
        m_data = '0; m_new = 0; m_ovr = 0; m_seq = 0; m_mask = '0; m_cnt = 0; m_prev = -1;
    endtask

    task automatic model_update(input bit rst, input bit tick, input logic [7:0] t,
                                input bit wr, input logic [1:0] a, input logic [31:0] wd);
        logic [2:0] c;
        bit seq_set;
        if (rst) begin
            model_reset();
            return;
        end
        c = (wr && a == 2'd1) ? wd[2:0] : 3'b000;
        seq_set = SEQ_EN && tick && m_prev >= 0 && int'(t[5:0]) != (m_prev + 1) % 64;
        m_ovr = (tick && m_new) || (m_ovr && !c[1]);
        m_new = tick || (m_new && !c[0]);
        m_seq = seq_set || (m_seq && !c[2]);
        if (wr && a == 2'd2) m_mask = SEQ_EN ? wd[2:0] : {1'b0, wd[1:0]};
        if (tick) m_cnt = (wr && a == 2'd3) ? 1 : (m_cnt + 1) % (1 << CW);
        else if (wr && a == 2'd3) m_cnt = 0;
        if (tick) begin
            m_data = t;
            m_prev = int'(t[5:0]);
        end
    endtask

    // One clock with the given inputs; returns #1 after the edge with inputs idle.
    task automatic step(input bit rst, input bit tick, input logic [7:0] t,
                        input bit wr, input logic [1:0] a, input logic [31:0] wd);
        reset_n    = !rst;
        tick_in    = tick;
        time_in    = t;
        chipselect = wr;
        write_n    = !wr;
        address    = a;
        writedata  = wd;
        @(posedge clk);
        #1;
        reset_n = 1'b1; tick_in = 1'b0; chipselect = 1'b0; write_n = 1'b1;
        model_update(rst, tick, t, wr, a, wd);
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [31:0] v);
        address = a;
        #1;
        v = readdata;
    endtask

    task automatic check_model(input string tag);
        logic [31:0] v;
        check({tag, " irq"}, {31'b0, irq}, {31'b0, |(m_status() & m_mask)});
        read_reg(2'd0, v); check({tag, " data"}, v, {24'b0, m_data});
        read_reg(2'd1, v); check({tag, " status"}, v, {29'b0, m_status()});
        read_reg(2'd2, v); check({tag, " mask"}, v, {29'b0, m_mask});
        read_reg(2'd3, v); check({tag, " count"}, v, 32'(m_cnt));
    endtask

    task automatic add(input bit rst, input bit tick, input logic [7:0] t, input bit wr,
                       input logic [1:0] a, input logic [31:0] wd, input logic [7:0] ed,
                       input logic [2:0] es, input logic [31:0] ec, input bit ei);
        vec_t v;
        v.rst = rst; v.tick = tick; v.t = t; v.wr = wr; v.a = a; v.wd = wd;
        v.e_data = ed; v.e_st = es; v.e_cnt = ec; v.e_irq = ei;
        vecs.push_back(v);
    endtask

    initial begin
        logic [2:0]  s2;
        logic [31:0] v;
        logic [7:0]  t;
        model_reset();
        s2 = SEQ_EN ? 3'b100 : 3'b000;

        //   rst tick time  wr addr wdata    data   status     cnt irq
        add(1, 0, 8'h00, 0, 2'd0, 32'h0, 8'h00, 3'h0,      0, 0);
        add(0, 1, 8'h05, 0, 2'd0, 32'h0, 8'h05, 3'h1,      1, 0);
        add(0, 0, 8'h00, 1, 2'd1, 32'h7, 8'h05, 3'h0,      1, 0);
        add(0, 0, 8'h00, 1, 2'd2, 32'h1, 8'h05, 3'h0,      1, 0);
        add(0, 1, 8'h06, 0, 2'd0, 32'h0, 8'h06, 3'h1,      2, 1);
        add(0, 0, 8'h00, 1, 2'd1, 32'h1, 8'h06, 3'h0,      2, 0);
        add(0, 1, 8'h07, 0, 2'd0, 32'h0, 8'h07, 3'h1,      3, 1);
        add(0, 1, 8'h08, 0, 2'd0, 32'h0, 8'h08, 3'h3,      4, 1);
        add(0, 0, 8'h00, 1, 2'd1, 32'h7, 8'h08, 3'h0,      4, 0);
        add(0, 1, 8'h3F, 0, 2'd0, 32'h0, 8'h3F, 3'h1 | s2, 5, 1);
        add(0, 0, 8'h00, 1, 2'd1, 32'h7, 8'h3F, 3'h0,      5, 0);
        add(0, 1, 8'h00, 0, 2'd0, 32'h0, 8'h00, 3'h1,      6, 1);
        add(0, 1, 8'hC1, 0, 2'd0, 32'h0, 8'hC1, 3'h3,      7, 1);
        add(0, 0, 8'h00, 1, 2'd1, 32'h7, 8'hC1, 3'h0,      7, 0);
        add(0, 0, 8'h00, 1, 2'd2, 32'h4, 8'hC1, 3'h0,      7, 0);
        add(0, 1, 8'h05, 0, 2'd0, 32'h0, 8'h05, 3'h1 | s2, 8, SEQ_EN);
        add(0, 1, 8'h06, 1, 2'd1, 32'h1, 8'h06, 3'h3 | s2, 9, SEQ_EN);
        add(0, 1, 8'h07, 1, 2'd3, 32'h0, 8'h07, 3'h3 | s2, 1, SEQ_EN);
        add(0, 0, 8'h00, 1, 2'd3, 32'h0, 8'h07, 3'h3 | s2, 0, SEQ_EN);
        add(0, 1, 8'h10, 1, 2'd1, 32'h4, 8'h10, 3'h3 | s2, 1, SEQ_EN);
        add(1, 1, 8'h20, 1, 2'd2, 32'h7, 8'h00, 3'h0,      0, 0);
        add(0, 1, 8'h2A, 0, 2'd0, 32'h0, 8'h2A, 3'h1,      1, 0);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].tick, vecs[i].t, vecs[i].wr, vecs[i].a, vecs[i].wd);
            check($sformatf("vec%0d irq", i), {31'b0, irq}, {31'b0, vecs[i].e_irq});
            read_reg(2'd0, v); check($sformatf("vec%0d data", i), v, {24'b0, vecs[i].e_data});
            read_reg(2'd1, v); check($sformatf("vec%0d status", i), v, {29'b0, vecs[i].e_st});
            read_reg(2'd3, v); check($sformatf("vec%0d count", i), v, vecs[i].e_cnt);
            check_model($sformatf("vec%0d model", i));
        end

        // Fifteen more in-sequence ticks bring the 4-bit counter from 1 round to 0.
        for (int i = 0; i < 15; i++) step(0, 1, 8'h2B + 8'(i), 0, 2'd0, 32'h0);
        read_reg(2'd3, v); check("wrap count", v, 32'h0);
        read_reg(2'd1, v); check("wrap status", v, 32'h3);
        check_model("wrap");

        // Reset in the middle of a burst clears everything; next tick is not a sequence error.
        step(0, 1, 8'h3A, 1, 2'd2, 32'h7);
        step(1, 1, 8'h11, 0, 2'd0, 32'h0);
        for (int a = 0; a < 4; a++) begin
            read_reg(2'(a), v);
            check($sformatf("midreset addr%0d", a), v, 32'h0);
        end
        check("midreset irq", {31'b0, irq}, 32'h0);
        step(0, 1, 8'h33, 0, 2'd0, 32'h0);
        read_reg(2'd1, v); check("post-reset status", v, 32'h1);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            bit         rr, tk, ww;
            logic [1:0] aa;
            logic [31:0] wd;
            rr = ($urandom_range(0, 63) == 0);
            tk = $urandom_range(0, 1) == 1;
            ww = $urandom_range(0, 2) == 0;
            aa = 2'($urandom_range(0, 3));
            wd = $urandom;
            if ($urandom_range(0, 3) == 0 || m_prev < 0) t = 8'($urandom);
            else t = {2'($urandom), 6'((m_prev + 1) % 64)};
            step(rr, tk, t, ww, aa, wd);
            check_model($sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spw_ulight_nofifo_timec_rx_capture.md
# spw_ulight_nofifo_timec_rx_capture

Avalon-MM slave that captures SpaceWire time-codes received by the ulight core and exposes them to the Nios II host. It complements the host-driven time-code transmit output port. The block latches each received time-code on the core's tick strobe and keeps sticky new/overrun/sequence-error flags. It also counts received ticks and raises a maskable level interrupt.

## Interface
- CNT_WIDTH, 16, width of the received-tick counter (1..32)
- clk  input  1  system clock; all logic on rising edge
- reset_n  input  1  synchronous, active-low reset
- address  input  2  register select
- chipselect  input  1  Avalon slave select
- write_n  input  1  active-low write strobe
- writedata  input  32  write data
- readdata  output  32  read data; combinational from address, zero wait states
- tick_in  input  1  single-cycle strobe from the SpaceWire core: a time-code was received
- time_in  input  8  received time-code ([7:6] control flags, [5:0] time value); valid when tick_in=1
- irq  output  1  level interrupt, active high

## Operation
- Write qualifier: `wr = chipselect & ~write_n`. There is no read side effect.
- Register map:
  - addr 0 DATA (RO): [7:0] = last captured time-code; upper bits 0.
  - addr 1 STATUS (W1C): bit0 NEW, bit1 OVERRUN, bit2 SEQERR; upper bits 0.
  - addr 2 IRQ_MASK (RW): [2:0] enable bits for STATUS[2:0].
  - addr 3 TICK_COUNT (RO, write-any clears): [CNT_WIDTH-1:0] = received ticks; upper bits 0.
- On tick_in=1:
  - DATA <= time_in.
  - NEW <= 1.
  - If NEW was already 1, OVERRUN <= 1.
  - TICK_COUNT <= TICK_COUNT+1, wrapping from all-ones to 0.
- Sequence check:
  - Internal REF_VALID flag (0 at reset) and REF[5:0] = time value of the previous tick.
  - On tick_in with REF_VALID=1 and time_in[5:0] != (REF+1) mod 64, SEQERR <= 1.
  - Every tick sets REF <= time_in[5:0] and REF_VALID <= 1.
  - The first tick after reset never flags SEQERR.
  - Control bits [7:6] are ignored by the check.
- W1C: a write to addr 1 clears each STATUS bit whose writedata bit is 1.
- Simultaneous events:
  - A set in the same cycle as a W1C of the same bit: set wins (bit stays 1).
  - OVERRUN is evaluated against NEW's value before the W1C.
  - Tick in the same cycle as a clearing write to addr 3: TICK_COUNT <= 1.
- irq = |(STATUS[2:0] & IRQ_MASK[2:0]), driven from registers (no combinational path from tick_in).
- Consecutive-cycle ticks are each captured and counted. The second one sets OVERRUN unless NEW was cleared in between.

## Timing
- Reset (reset_n=0 at a clk edge) zeroes DATA, STATUS, IRQ_MASK, TICK_COUNT, REF and REF_VALID. Hence irq=0 and readdata=0 for every address.
- Reset asserted together with tick_in or a write: reset wins.
- tick_in high at edge N → DATA, flags and count are updated after edge N and visible on readdata in cycle N+1. irq rises in cycle N+1 when masked-in.
- Register writes take effect after the write edge. irq drops the cycle after a W1C or mask-clear.
- readdata follows address combinationally in the same cycle.

## Configuration
- SPW_TIMEC_RX_SEQCHK_EN defined: REF, REF_VALID and SEQERR logic are implemented as described.
- Not defined: STATUS bit2 is tied to 0, IRQ_MASK[2] reads back 0, and no SEQERR interrupt is possible. All other behaviour is unchanged.

## Test plan
- Reset then read all four addresses → all 0, irq=0. Pulse tick_in with time_in=0x05 → DATA=0x05, STATUS=0x1, TICK_COUNT=1 in the next cycle.
- IRQ_MASK=0x1, tick time_in=0x06 → irq=1 in cycle N+1. Write STATUS 0x1 → irq=0 the cycle after.
- Two ticks 0x07 then 0x08 without clearing → STATUS=0x3 (NEW|OVERRUN), DATA=0x08, no SEQERR.
- With the macro: ticks 0x3F then 0x00 → no SEQERR (wrap). Then 0x05 → SEQERR=1; with IRQ_MASK=0x4, irq=1. Without the macro, the same stimulus gives STATUS bit2=0.
- W1C of NEW in the same cycle as a tick → NEW stays 1. Write addr 3 in the same cycle as a tick → TICK_COUNT=1.
- CNT_WIDTH=4: 16 ticks → TICK_COUNT=0. Assert reset_n=0 mid-sequence → all registers 0. The next tick after reset sets no SEQERR.
